// File: rtl/led_fade_pwm_pkg.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_pkg
// Shared definitions for the LED fade/PWM block: FSM state encodings, duty
// width and full-scale value, and the optional gamma mapping used when the
// block is built with LED_FADE_GAMMA_EN defined.
// ---------------------------------------------------------------------------
package led_fade_pwm_pkg;

  // Width of the PWM counter and of every duty value.
  localparam int PWM_BITS = 8;

  // Full-scale duty: LED permanently on.
  localparam logic [PWM_BITS-1:0] DUTY_MAX = 8'd255;

  // Fade FSM states; the encodings are fixed so they read the same in
  // waveforms across every build of this block.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RISE = 2'd1,
    ST_ON   = 2'd2,
    ST_FALL = 2'd3
  } fade_state_t;

  // Perceptual correction: (d*d)>>8, with full scale pinned at 255 so the
  // ON state really drives the LED constantly high.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    if (d == DUTY_MAX) begin
      return DUTY_MAX;
    end
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction

endpackage

// File: rtl/led_fade_pwm_pwm_gen.sv
// ---------------------------------------------------------------------------
// led_fade_pwm_pwm_gen
// 8-bit PWM generator: prescaler, free-running PWM counter, period-boundary
// latch of the duty value and the final compare that drives the LED.
// The duty is only sampled when the counter wraps 255->0, so a duty that
// changes mid-period never produces a runt or double pulse.
// ---------------------------------------------------------------------------
module led_fade_pwm_pwm_gen
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned PWM_DIV = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_led
);

  localparam int unsigned         PRE_W    = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = DUTY_MAX;

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_duty_act;
  logic                w_pre_tick;
  logic                w_wrap;

  assign w_pre_tick = (r_pre == PRE_LAST);
  assign w_wrap     = w_pre_tick && (r_pwm_cnt == CNT_LAST);

  // Prescaler: one tick every PWM_DIV clocks advances the PWM counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
    end else if (w_pre_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // PWM counter: free-running, wraps naturally from 255 to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_cnt <= '0;
    end else if (w_pre_tick) begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Duty latch: take the new duty only at the start of a PWM period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty_act <= '0;
    end else if (w_wrap) begin
      r_duty_act <= i_duty;
    end
  end

  // Compare: full scale is forced high so 255 means "always on", not 255/256.
  assign o_led = (r_duty_act == DUTY_MAX) ? 1'b1 : (r_pwm_cnt < r_duty_act);

endmodule

// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
// Turns the 1-bit blink level into a linear brightness fade on the LED pin.
// Holds the input register, the OFF/RISE/ON/FALL fade FSM, the ramp tick
// counter and the optional gamma stage; the PWM itself lives in
// led_fade_pwm_pwm_gen.
// Build option: define LED_FADE_GAMMA_EN to pass the linear ramp through a
// square-law gamma curve before it reaches DUTY; otherwise DUTY is linear.
// ---------------------------------------------------------------------------
module led_fade_pwm
  import led_fade_pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned PWM_DIV  = 4,
  parameter int unsigned RAMP_DIV = 11_718
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_blink,
  output logic                o_led,
  output logic [PWM_BITS-1:0] o_duty,
  output logic                o_busy
);

  localparam int unsigned       RAMP_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  // Reject configurations that cannot produce a sensible fade.
  if ((CLK_FREQ == 0) || (PWM_DIV == 0) || (RAMP_DIV == 0)) begin : g_param_check
    $error("led_fade_pwm: CLK_FREQ, PWM_DIV and RAMP_DIV must all be non-zero");
  end

  logic                r_blink_q;
  fade_state_t         r_state;
  fade_state_t         w_state_nxt;
  logic [RAMP_W-1:0]   r_ramp_cnt;
  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] w_duty_out;
  logic                w_busy;
  logic                w_stay;
  logic                w_tick;

  // Input register: the FSM only ever looks at the registered blink level.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of always-block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_q <= 1'b0;
    end else begin
      r_blink_q <= i_blink;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A reversal keeps the current duty; a request for the
  // level we are already sitting at goes straight to the matching rest state.
  // NOTE: the default assignment first keeps this purely combinational; any
  // path that left w_state_nxt unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_OFF: begin
        if (r_blink_q) begin
          w_state_nxt = ST_RISE;
        end
      end
      ST_RISE: begin
        if (!r_blink_q) begin
          w_state_nxt = (r_duty == '0) ? ST_OFF : ST_FALL;
        end else if (r_duty == DUTY_MAX) begin
          w_state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (!r_blink_q) begin
          w_state_nxt = ST_FALL;
        end
      end
      ST_FALL: begin
        if (r_blink_q) begin
          w_state_nxt = (r_duty == DUTY_MAX) ? ST_ON : ST_RISE;
        end else if (r_duty == '0) begin
          w_state_nxt = ST_OFF;
        end
      end
      default: w_state_nxt = ST_OFF;
    endcase
  end

  assign w_busy = (r_state == ST_RISE) || (r_state == ST_FALL);
  assign w_stay = (w_state_nxt == r_state);
  assign w_tick = (r_ramp_cnt == RAMP_LAST);

  // Ramp tick counter: restarts on every state entry and idles at 0 when the
  // FSM is at rest, so each ramp step is exactly RAMP_DIV clocks long.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ramp_cnt <= '0;
    end else if (!w_stay || !w_busy || w_tick) begin
      r_ramp_cnt <= '0;
    end else begin
      r_ramp_cnt <= r_ramp_cnt + RAMP_W'(1);
    end
  end

  // Linear duty: one step per ramp tick while staying in RISE/FALL, clamped
  // at both ends so it never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_duty <= '0;
    end else if (w_stay && w_tick) begin
      case (r_state)
        ST_RISE: if (r_duty != DUTY_MAX) r_duty <= r_duty + PWM_BITS'(1);
        ST_FALL: if (r_duty != '0)       r_duty <= r_duty - PWM_BITS'(1);
        default: ;
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  assign w_duty_out = gamma_map(r_duty);
`else
  assign w_duty_out = r_duty;
`endif

  led_fade_pwm_pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_duty  (w_duty_out),
    .o_led   (o_led)
  );

  assign o_duty = w_duty_out;
  assign o_busy = w_busy;

endmodule
